// File: rtl/jt12_pcm_interpol_mc.sv
// Multichannel linear PCM interpolator: each channel ramps from its previous
// sample to the new one at cen55 rate, with one sequential divider shared by all channels for the slopes.
module jt12_pcm_interpol_mc #(
   parameter int DW    = 9,
   parameter int CH    = 2,
   parameter int STEPW = 5,
   parameter int FRACW = 8,
   localparam int CHW  = $clog2(CH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen55,
   input  logic             interp_en,
   input  logic             wr,
   input  logic [CHW-1:0]   wr_ch,
   input  logic [DW-1:0]    pcmin,
   output logic [CH*DW-1:0] pcmout,
   output logic [CH-1:0]    busy
);
   localparam int QW   = DW + 1 + FRACW;
   localparam int AW   = DW + FRACW + 1;
   localparam int SW   = AW + 2;
   localparam int CNTW = $clog2(QW);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   state_t state_reg, state_next;

   logic [CHW-1:0]   cur_reg, grant_ch;
   logic [CNTW-1:0]  cnt_reg;
   logic [QW-1:0]    quo_reg;
   logic [STEPW:0]   rem_reg, rem_sh;
   logic [STEPW-1:0] div_reg;
   logic             neg_reg, grant, abort;
   logic signed [DW:0] diff;
   logic [DW:0]      mag;

   logic [CH-1:0]        pend_vec;
   logic signed [DW-1:0] new_arr  [CH];
   logic signed [DW-1:0] last_arr [CH];
   logic [STEPW-1:0]     dn_arr   [CH];

   // lowest pending channel wins the divider
   always_comb begin
      grant_ch = '0;
      for (int i = CH - 1; i >= 0; i--)
         if (pend_vec[i]) grant_ch = CHW'(i);
   end

   assign abort = wr && (wr_ch == cur_reg) && (state_reg != IDLE);

   always_comb begin
      state_next = state_reg;
      grant      = 1'b0;
      case (state_reg)
         IDLE: if (|pend_vec) begin
            grant      = 1'b1;
            state_next = LOAD;
         end
         LOAD: state_next = RUN;
         RUN:  if (cnt_reg == CNTW'(QW - 1)) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (abort) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   assign diff   = {new_arr[cur_reg][DW-1], new_arr[cur_reg]} - {last_arr[cur_reg][DW-1], last_arr[cur_reg]};
   assign mag    = diff[DW] ? $unsigned(-diff) : $unsigned(diff);
   assign rem_sh = {rem_reg[STEPW-1:0], quo_reg[QW-1]};

   // restoring division: the dividend shifts out of quo_reg as quotient bits shift in
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_reg <= '0;
         cnt_reg <= '0;
         quo_reg <= '0;
         rem_reg <= '0;
         div_reg <= '0;
         neg_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: if (grant) cur_reg <= grant_ch;
            LOAD: begin
               quo_reg <= {mag, {FRACW{1'b0}}};
               neg_reg <= diff[DW];
               div_reg <= dn_arr[cur_reg];
               rem_reg <= '0;
               cnt_reg <= '0;
            end
            RUN: begin
               cnt_reg <= cnt_reg + CNTW'(1);
               if (rem_sh >= {1'b0, div_reg}) begin
                  rem_reg <= rem_sh - {1'b0, div_reg};
                  quo_reg <= {quo_reg[QW-2:0], 1'b1};
               end else begin
                  rem_reg <= rem_sh;
                  quo_reg <= {quo_reg[QW-2:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_ch
         logic signed [AW-1:0] acc_reg, acc_next, target;
         logic signed [SW-1:0] acc_ext, tgt_ext, step_ext, ramp;
         logic signed [DW-1:0] new_reg, last_reg, out_reg;
         logic [QW-1:0]        step_reg;
         logic [STEPW-1:0]     pre_dn_reg, dn_reg;
         logic                 sgn_reg, pending_reg, wr_hit, done_hit;

         assign wr_hit   = wr && (wr_ch == CHW'(gi));
         assign done_hit = (state_reg == DONE) && (cur_reg == CHW'(gi)) && !abort;
         assign busy[gi] = pending_reg | ((state_reg != IDLE) && (cur_reg == CHW'(gi)));

         assign pend_vec[gi]          = pending_reg;
         assign new_arr[gi]           = new_reg;
         assign last_arr[gi]          = last_reg;
         assign dn_arr[gi]            = dn_reg;
         assign pcmout[gi*DW +: DW]   = out_reg;

         assign target   = {new_reg[DW-1], new_reg, {FRACW{1'b0}}};
         assign acc_ext  = {{2{acc_reg[AW-1]}}, acc_reg};
         assign tgt_ext  = {{2{target[AW-1]}}, target};
         assign step_ext = {2'b00, step_reg};

         // the ramp is computed two bits wider so a step past the target is caught before wrapping
         always_comb begin
            ramp     = sgn_reg ? (acc_ext - step_ext) : (acc_ext + step_ext);
            acc_next = acc_reg;
            if (!interp_en)
               acc_next = target;
            else if (!busy[gi]) begin
               if (sgn_reg ? (ramp <= tgt_ext) : (ramp >= tgt_ext))
                  acc_next = target;
               else
                  acc_next = ramp[AW-1:0];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               acc_reg     <= '0;
               new_reg     <= '0;
               last_reg    <= '0;
               out_reg     <= '0;
               step_reg    <= '0;
               sgn_reg     <= 1'b0;
               pre_dn_reg  <= '1;
               dn_reg      <= STEPW'(1);
               pending_reg <= 1'b0;
            end else begin
               if (grant && (grant_ch == CHW'(gi))) pending_reg <= 1'b0;
               if (wr_hit) pending_reg <= 1'b1;
               if (done_hit) begin
                  step_reg <= quo_reg;
                  sgn_reg  <= neg_reg;
               end
               if (cen55) begin
                  out_reg <= acc_reg[FRACW +: DW];
                  acc_reg <= acc_next;
               end
               // a write overrides the cen55 accumulator update
               if (wr_hit) begin
                  acc_reg    <= target;
                  last_reg   <= new_reg;
                  new_reg    <= pcmin;
                  dn_reg     <= (pre_dn_reg == '0) ? STEPW'(1) : pre_dn_reg;
                  pre_dn_reg <= cen55 ? STEPW'(1) : '0;
               end else if (cen55 && (pre_dn_reg != '1)) begin
                  pre_dn_reg <= pre_dn_reg + STEPW'(1);
               end
            end
         end
      end
   endgenerate
endmodule
